fetch_icache_unit: RTL and testbench
====================================

Name: fetch_icache_unit

Overview:
Instruction fetch stage: holds the 64-bit PC and a direct-mapped instruction cache. It refills missing lines from instruction memory through a ready handshake. It presents pc_out, instruction and hit to the IF/ID pipeline register, which captures only when hit=1. Branch redirects come from the execute stage; stalls come from the hazard unit.

Parameters:
LINES, 16, number of cache lines (power of 2, ≥2)
WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥2)
RESET_PC, 64'h0, PC value after reset

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
stall  in  1  hold PC (hazard unit)
branch_taken  in  1  redirect request, valid this cycle
branch_target  in  64  redirect address
mem_req  out  1  refill word request
mem_addr  out  64  word-aligned refill address
mem_ready  in  1  mem_rdata valid / request accepted this cycle
mem_rdata  in  32  refill word
pc_out  out  64  current fetch PC
instruction  out  32  instruction at pc_out (valid when hit=1)
hit  out  1  pc_out hits a valid line and state is IDLE

Behaviour:
- Address split of pc: [1:0] byte (ignored), next log2(WORDS_PER_LINE) bits = word, next log2(LINES) bits = index, remaining upper bits = tag.
- Reset (rst=1 at posedge, any state including mid-refill):
  - pc_out=RESET_PC, all valid bits=0, state=IDLE.
  - mem_req=0, mem_addr=0, word counter=0, pending-branch flag=0.
  - Data/tag arrays are not cleared.
- hit = valid[index] & tag match & state==IDLE, combinational. instruction = data[index][word], combinational (don't-care when hit=0).
- FSM states: IDLE, REFILL.
- IDLE, priority highest first:
  1. branch_taken: pc <= {branch_target[63:2],2'b00}. No refill starts this cycle.
  2. hit & !stall: pc <= pc+4. Wraps modulo 2^64.
  3. hit & stall: pc held.
  4. !hit: latch refill base = {pc tag, index, zero word, 2'b00}; counter <= 0; mem_req <= 1; state <= REFILL.
- REFILL:
  - mem_addr = base + 4*counter.
  - mem_req=1 until the last beat is accepted.
  - On mem_ready=1: data[index][counter] <= mem_rdata; counter++.
  - On the last beat (counter==WORDS_PER_LINE-1): tag/valid written, mem_req <= 0, state <= IDLE.
  - PC is frozen during refill; stall is ignored.
  - Earliest hit is the cycle after the last beat.
  - Refill of a valid index evicts the old line: valid is cleared at refill start and set at completion.
- branch_taken during REFILL: target latched into the pending register (a later branch overwrites it). The refill still completes. On the IDLE entry cycle pc <= pending target and the pending flag clears; hit is suppressed that cycle.
- branch_taken on the same cycle as the last refill beat: also handled via the pending path.
- mem_ready while mem_req=0: ignored.

Decomposition:
- ifetch_pkg holds:
  - ADDR_W=64, INSTR_W=32
  - localparam functions for index/word/tag widths
  - state encoding: IDLE=1'b0, REFILL=1'b1
- One sub-module, icache_array:
  - tag/valid/data storage
  - combinational read port; single write port (word write plus tag/valid set/clear)
  - synchronous valid clear on rst
- The fetch_icache_unit top holds the PC, FSM, counter and pending-branch logic.

Test Plan:
1. Cold miss: reset, RESET_PC=0; memory answers mem_ready 2 cycles after each request, words 0xE3A00001..0xE3A00004. Required:
   - mem_addr 0,4,8,C in order.
   - hit=1 the cycle after the 4th beat, with instruction=0xE3A00001.
   - Next three cycles: pc_out 4,8,C with the matching words.
   - Then a miss at 0x10.
2. Stall: with hit=1 at pc 0x4, hold stall=1 for 3 cycles. pc_out stays 0x4 and instruction is stable; pc 0x8 the cycle after stall drops.
3. Conflict eviction: fill the line at 0x000, then branch to 0x100 (same index 0, different tag). Required:
   - miss and refill from 0x100..0x10C;
   - a branch back to 0x000 misses again.
4. Branch during refill:
   - Assert branch_taken, target 0x203, on the 2nd refill beat.
   - The refill completes all 4 words.
   - Then pc_out=0x200, followed by a miss/refill at 0x200.
5. Reset mid-refill: assert rst after beat 2. Required:
   - next cycle mem_req=0, pc_out=0, hit=0;
   - the next fetch of 0x0 refills from beat 0.
6. Branch beats increment: hit at pc 0x8 with branch_taken to 0x40 and stall=1 simultaneously gives pc_out=0x40 next cycle.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared widths, address-field helpers and FSM encoding for the fetch/icache slice.
package ifetch_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } fetch_state_e;

  function automatic int word_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int words_per_line);
    return ADDR_W - 2 - $clog2(lines) - $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped instruction cache storage: tag/valid/data arrays with one
// combinational read port and a single write port.
module icache_array
  import ifetch_pkg::*;
#(
  parameter int  LINES          = 16,
  parameter int  WORDS_PER_LINE = 4,
  localparam int IW             = index_w(LINES),
  localparam int WW             = word_w(WORDS_PER_LINE),
  localparam int TW             = tag_w(LINES, WORDS_PER_LINE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IW-1:0]      rd_index,
  input  logic [WW-1:0]      rd_word,
  output logic               rd_valid,
  output logic [TW-1:0]      rd_tag,
  output logic [INSTR_W-1:0] rd_data,
  input  logic [IW-1:0]      wr_index,
  input  logic [WW-1:0]      wr_word,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               wr_word_en,
  input  logic [TW-1:0]      wr_tag,
  input  logic               wr_tag_set,
  input  logic               wr_valid_clr
);

  logic [INSTR_W-1:0] data_mem_r [LINES][WORDS_PER_LINE];
  logic [TW-1:0]      tag_mem_r  [LINES];
  logic [LINES-1:0]   valid_r;

  // Data and tag storage; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_word_en) begin
      data_mem_r[wr_index][wr_word] <= wr_data;
    end
    if (wr_tag_set) begin
      tag_mem_r[wr_index] <= wr_tag;
    end
  end

  // Valid bits: cleared on reset, cleared at refill start, set at refill end.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (wr_tag_set) begin
      valid_r[wr_index] <= 1'b1;
    end else if (wr_valid_clr) begin
      valid_r[wr_index] <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign rd_valid = valid_r[rd_index];
  assign rd_tag   = tag_mem_r[rd_index];
  assign rd_data  = data_mem_r[rd_index][rd_word];

endmodule

// File: rtl/fetch_icache_unit.sv
// Instruction fetch stage: PC, refill FSM and pending-branch capture around a
// direct-mapped instruction cache.
module fetch_icache_unit
  import ifetch_pkg::*;
#(
  parameter int          LINES          = 16,
  parameter int          WORDS_PER_LINE = 4,
  parameter logic [63:0] RESET_PC       = 64'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] instruction,
  output logic               hit
);

  localparam int IW      = index_w(LINES);
  localparam int WW      = word_w(WORDS_PER_LINE);
  localparam int TW      = tag_w(LINES, WORDS_PER_LINE);
  localparam int IDX_LSB = 2 + WW;
  localparam int TAG_LSB = 2 + WW + IW;
  localparam logic [WW-1:0] LAST_WORD = WW'(WORDS_PER_LINE - 1);

  fetch_state_e       state_r, state_s;
  logic [ADDR_W-1:0]  pc_r, pc_s;
  logic [WW-1:0]      count_r, count_s;
  logic               pend_r, pend_s;
  logic [ADDR_W-1:0]  pend_target_r, pend_target_s;
  logic               mem_req_r, mem_req_s;
  logic [ADDR_W-1:0]  mem_addr_r, mem_addr_s;

  logic [IW-1:0]      pc_index_s, wr_index_s;
  logic [WW-1:0]      pc_word_s;
  logic [TW-1:0]      pc_tag_s, line_tag_s;
  logic               line_valid_s;
  logic               wr_word_en_s, wr_tag_set_s, wr_valid_clr_s;
  logic [ADDR_W-1:0]  branch_pc_s;
  logic               unused_branch_bits;

  assign pc_word_s   = pc_r[IDX_LSB-1:2];
  assign pc_index_s  = pc_r[TAG_LSB-1:IDX_LSB];
  assign pc_tag_s    = pc_r[ADDR_W-1:TAG_LSB];
  assign branch_pc_s = {branch_target[ADDR_W-1:2], 2'b00};
  assign unused_branch_bits = ^branch_target[1:0];

  // mem_addr never leaves its line during a refill, so it also names the line being filled.
  assign wr_index_s = (state_r == REFILL) ? mem_addr_r[TAG_LSB-1:IDX_LSB] : pc_index_s;

  // The IDLE entry cycle that redirects to a pending branch never reports a hit.
  assign hit = line_valid_s && (line_tag_s == pc_tag_s) && (state_r == IDLE) && !pend_r;

  assign pc_out   = pc_r;
  assign mem_req  = mem_req_r;
  assign mem_addr = mem_addr_r;

  icache_array #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_array (
    .clk          (clk),
    .rst          (rst),
    .rd_index     (pc_index_s),
    .rd_word      (pc_word_s),
    .rd_valid     (line_valid_s),
    .rd_tag       (line_tag_s),
    .rd_data      (instruction),
    .wr_index     (wr_index_s),
    .wr_word      (count_r),
    .wr_data      (mem_rdata),
    .wr_word_en   (wr_word_en_s),
    .wr_tag       (mem_addr_r[ADDR_W-1:TAG_LSB]),
    .wr_tag_set   (wr_tag_set_s),
    .wr_valid_clr (wr_valid_clr_s)
  );

  // Next-state, PC, refill sequencing and cache write controls.
  always_comb begin
    state_s        = state_r;
    pc_s           = pc_r;
    count_s        = count_r;
    pend_s         = pend_r;
    pend_target_s  = pend_target_r;
    mem_req_s      = mem_req_r;
    mem_addr_s     = mem_addr_r;
    wr_word_en_s   = 1'b0;
    wr_tag_set_s   = 1'b0;
    wr_valid_clr_s = 1'b0;

    case (state_r)
      IDLE: begin
        pend_s = 1'b0;
        if (rst) begin
          pc_s = pc_r;
        end else if (branch_taken) begin
          pc_s = branch_pc_s;
        end else if (pend_r) begin
          pc_s = pend_target_r;
        end else if (hit) begin
          if (!stall) begin
            pc_s = pc_r + 64'd4;
          end else begin
            pc_s = pc_r;
          end
        end else begin
          mem_addr_s     = {pc_r[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}};
          count_s        = '0;
          mem_req_s      = 1'b1;
          wr_valid_clr_s = 1'b1;
          state_s        = REFILL;
        end
      end

      REFILL: begin
        if (branch_taken) begin
          pend_s        = 1'b1;
          pend_target_s = branch_pc_s;
        end else begin
          pend_s = pend_r;
        end
        if (mem_req_r && mem_ready && !rst) begin
          wr_word_en_s = 1'b1;
          count_s      = count_r + 1'b1;
          if (count_r == LAST_WORD) begin
            wr_tag_set_s = 1'b1;
            mem_req_s    = 1'b0;
            state_s      = IDLE;
          end else begin
            mem_addr_s = mem_addr_r + 64'd4;
          end
        end else begin
          count_s = count_r;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      count_r       <= '0;
      pend_r        <= 1'b0;
      pend_target_r <= 64'h0;
      mem_req_r     <= 1'b0;
      mem_addr_r    <= 64'h0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      count_r       <= count_s;
      pend_r        <= pend_s;
      pend_target_r <= pend_target_s;
      mem_req_r     <= mem_req_s;
      mem_addr_r    <= mem_addr_s;
    end
  end

endmodule

// File: tb/tb_fetch_icache_unit.sv
// Self-checking bench for fetch_icache_unit: refill addresses are scoreboarded,
// fetch results are checked against a simple memory image.
module tb_fetch_icache_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [63:0] pc_out;
  logic [31:0] instruction;
  logic        hit;

  int          checks = 0;
  int          errors = 0;
  int          beats_done = 0;
  int          wait_cnt = 0;
  logic [63:0] sb_addr[$];

  always #5 clk = ~clk;

  fetch_icache_unit #(
    .LINES          (16),
    .WORDS_PER_LINE (4),
    .RESET_PC       (64'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .pc_out        (pc_out),
    .instruction   (instruction),
    .hit           (hit)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'hE3A00001 + a[33:2];
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [63:0] base);
    for (int i = 0; i < 4; i++) sb_addr.push_back(base + 64'(4 * i));
  endtask

  task automatic wait_hit(input string tag);
    int   n = 0;
    logic prev_req = 1'b0;
    while (!hit && n < 200) begin
      prev_req = mem_req;
      tick();
      n++;
    end
    check_eq({tag, "_hit"}, 64'(hit), 64'd1);
    check_eq({tag, "_hit_after_last_beat"}, 64'(prev_req), 64'd1);
    check_eq({tag, "_all_beats"}, 64'(sb_addr.size()), 64'd0);
  endtask

  task automatic check_fetch(input string tag, input logic [63:0] pc_exp);
    check_eq({tag, "_pc"}, pc_out, pc_exp);
    check_eq({tag, "_hit"}, 64'(hit), 64'd1);
    check_eq({tag, "_instr"}, 64'(instruction), 64'(mem_word(pc_exp)));
  endtask

  task automatic do_branch(input logic [63:0] target, input logic with_stall);
    branch_taken  = 1'b1;
    branch_target = target;
    stall         = with_stall;
    tick();
    branch_taken  = 1'b0;
    stall         = 1'b0;
  endtask

  // Memory responder: ready two cycles after each request; pops expected addresses.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_ready) begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
        beats_done++;
      end else if (mem_req === 1'b1) begin
        wait_cnt++;
        if (wait_cnt == 2) begin
          mem_ready = 1'b1;
          mem_rdata = mem_word(mem_addr);
          if (sb_addr.size() == 0) check_eq("refill_unexpected", 64'(sb_addr.size()), 64'd1);
          else check_eq("refill_addr", mem_addr, sb_addr.pop_front());
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
    tick();
    tick();
    check_eq("rst_pc", pc_out, 64'h0);
    check_eq("rst_hit", 64'(hit), 64'd0);
    check_eq("rst_mem_req", 64'(mem_req), 64'd0);
    check_eq("rst_mem_addr", mem_addr, 64'h0);

    // Cold miss at 0x0, then sequential fetch, then miss at 0x10.
    push_line(64'h0);
    rst = 1'b0;
    wait_hit("cold");
    check_fetch("cold_w0", 64'h0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check_fetch("cold_seq", 64'(4 * i));
    end
    push_line(64'h10);
    tick();
    check_eq("miss10_pc", pc_out, 64'h10);
    check_eq("miss10_hit", 64'(hit), 64'd0);
    tick();
    check_eq("miss10_req", 64'(mem_req), 64'd1);
    check_eq("miss10_addr", mem_addr, 64'h10);
    wait_hit("miss10");
    check_fetch("miss10_w0", 64'h10);

    // Stall holds PC for three cycles.
    do_branch(64'h4, 1'b0);
    check_fetch("stall_entry", 64'h4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_fetch("stall_hold", 64'h4);
    end
    stall = 1'b0;
    tick();
    check_fetch("stall_release", 64'h8);

    // Branch beats stall.
    push_line(64'h40);
    do_branch(64'h40, 1'b1);
    check_eq("brstall_pc", pc_out, 64'h40);
    check_eq("brstall_hit", 64'(hit), 64'd0);
    wait_hit("line40");
    check_fetch("line40_w0", 64'h40);

    // Conflict eviction on index 0.
    push_line(64'h100);
    do_branch(64'h100, 1'b0);
    check_eq("evict_pc", pc_out, 64'h100);
    check_eq("evict_miss", 64'(hit), 64'd0);
    wait_hit("line100");
    check_fetch("line100_w0", 64'h100);
    push_line(64'h0);
    do_branch(64'h0, 1'b0);
    check_eq("back0_miss", 64'(hit), 64'd0);
    wait_hit("back0");
    check_fetch("back0_w0", 64'h0);

    // Branch during the second refill beat.
    push_line(64'h80);
    push_line(64'h200);
    beats_done = 0;
    do_branch(64'h80, 1'b0);
    n = 0;
    while (!(mem_ready && beats_done == 1) && n < 200) begin tick(); n++; end
    check_eq("br_refill_beat2_seen", 64'(beats_done), 64'd1);
    do_branch(64'h203, 1'b0);
    n = 0;
    while (mem_req && n < 200) begin tick(); n++; end
    check_eq("br_refill_done", 64'(mem_req), 64'd0);
    check_eq("br_entry_pc", pc_out, 64'h80);
    check_eq("br_entry_hit_suppressed", 64'(hit), 64'd0);
    check_eq("br_refill_beats", 64'(sb_addr.size()), 64'd4);
    tick();
    check_eq("br_redirect_pc", pc_out, 64'h200);
    check_eq("br_redirect_miss", 64'(hit), 64'd0);
    tick();
    check_eq("br_refill200_addr", mem_addr, 64'h200);
    wait_hit("line200");
    check_fetch("line200_w0", 64'h200);
    do_branch(64'h84, 1'b0);
    check_fetch("line80_filled", 64'h84);

    // Reset in the middle of a refill.
    push_line(64'h300);
    beats_done = 0;
    do_branch(64'h300, 1'b0);
    n = 0;
    while (beats_done < 2 && n < 200) begin tick(); n++; end
    check_eq("midrst_beats", 64'(beats_done), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_req", 64'(mem_req), 64'd0);
    check_eq("midrst_pc", pc_out, 64'h0);
    check_eq("midrst_hit", 64'(hit), 64'd0);
    sb_addr.delete();
    push_line(64'h0);
    tick();
    check_eq("midrst_refill_req", 64'(mem_req), 64'd1);
    check_eq("midrst_refill_addr", mem_addr, 64'h0);
    wait_hit("midrst");
    check_fetch("midrst_w0", 64'h0);
    tick();
    check_fetch("midrst_w1", 64'h4);

    check_eq("sb_drained", 64'(sb_addr.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
